// File: rtl/array_drain.sv
// Bottom-edge drain of the systolic array: deskews per-column results, saturates
// them to the MUL_BW fixed-point format and buffers rows in an output FIFO.
module array_drain #(
    parameter int COLS   = 4,
    parameter int INT_BW = 5,
    parameter int FRA_BW = 10,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld_i,
    input  logic [COLS*ACC_BW-1:0]   o_i,
    output logic                     stall_o,
    output logic [COLS*MUL_BW-1:0]   out_data_o,
    output logic                     out_vld_o,
    input  logic                     out_rdy_i,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                     ovf_o,
    input  logic                     clr_i
);

    localparam int LW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(DEPTH+COLS+1);

    // Arithmetic shift first so every bit of the shifted value feeds either the
    // range check or the result.
    function automatic logic [MUL_BW-1:0] sat_elem(input logic signed [ACC_BW-1:0] acc);
        logic signed [ACC_BW-1:0]           sh;
        logic [ACC_BW-INT_BW-FRA_BW-1:0]    top;
        sh  = acc >>> FRA_BW;
        top = sh[ACC_BW-1:INT_BW+FRA_BW];
        if ((&top) || !(|top))
            return sh[MUL_BW-1:0];
        else if (sh[ACC_BW-1])
            return {1'b1, {(MUL_BW-1){1'b0}}};
        else
            return {1'b0, {(MUL_BW-1){1'b1}}};
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    logic [COLS-1:0]          vld_q;
    logic [ACC_BW-1:0]        aligned [COLS];
    logic [COLS*MUL_BW-1:0]   sat_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_vld_i;
            for (int k = 1; k < COLS; k++)
                vld_q[k] <= vld_q[k-1];
        end
    end

    // Column c is captured c edges late, then delayed COLS-1-c more edges.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [ACC_BW-1:0] sr [COLS-c];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < COLS-c; k++)
                    sr[k] <= '0;
            end else begin
                sr[0] <= o_i[c*ACC_BW +: ACC_BW];
                for (int k = 1; k < COLS-c; k++)
                    sr[k] <= sr[k-1];
            end
        end
        assign aligned[c] = sr[COLS-1-c];
        assign sat_row[c*MUL_BW +: MUL_BW] = sat_elem(aligned[c]);
    end

    logic [COLS*MUL_BW-1:0] mem [DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr, rd_nxt;
    logic [LW-1:0]          cnt_nxt;
    logic [COLS*MUL_BW-1:0] head_nxt;
    logic                   pop, push, drop, full;
    logic [SW-1:0]          pending;

    always_comb begin
        pop      = out_vld_o && out_rdy_i;
        full     = (level_o == LW'(DEPTH));
        push     = vld_q[COLS-1] && (!full || pop);
        drop     = vld_q[COLS-1] && full && !pop;
        cnt_nxt  = level_o + LW'(push) - LW'(pop);
        rd_nxt   = pop ? ptr_inc(rd_ptr) : rd_ptr;
        // The new head may be the row being written this same edge.
        head_nxt = (push && (rd_nxt == wr_ptr)) ? sat_row : mem[rd_nxt];
    end

    always_comb begin
        pending = '0;
        for (int k = 0; k < COLS; k++)
            pending = pending + SW'(vld_q[k]);
    end

    assign stall_o = (SW'(level_o) + pending) >= SW'(DEPTH);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= sat_row;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_o    <= '0;
            out_vld_o  <= 1'b0;
            out_data_o <= '0;
            ovf_o      <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            rd_ptr    <= rd_nxt;
            level_o   <= cnt_nxt;
            out_vld_o <= (cnt_nxt != '0);
            if (cnt_nxt != '0)
                out_data_o <= head_nxt;
            if (drop)
                ovf_o <= 1'b1;
            else if (clr_i)
                ovf_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_array_drain.sv
// Bench for array_drain: directed scenarios plus random traffic, checked against a
// queue-based model of row arrival, saturation and FIFO occupancy.
module tb_array_drain;

    localparam int COLS  = 4;
    localparam int DEPTH = 8;
    localparam longint MAXV = (64'sd1 <<< 25) - 1;
    localparam longint MINV = -(64'sd1 <<< 25);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_vld_i = 1'b0;
    logic [127:0]   o_i = '0;
    logic           stall_o;
    logic [63:0]    out_data_o;
    logic           out_vld_o;
    logic           out_rdy_i = 1'b0;
    logic [3:0]     level_o;
    logic           ovf_o;
    logic           clr_i = 1'b0;

    array_drain dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld_i   (in_vld_i),
        .o_i        (o_i),
        .stall_o    (stall_o),
        .out_data_o (out_data_o),
        .out_vld_o  (out_vld_o),
        .out_rdy_i  (out_rdy_i),
        .level_o    (level_o),
        .ovf_o      (ovf_o),
        .clr_i      (clr_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           e;
        logic [127:0] d;
    } fl_t;

    fl_t         inflight[$];
    logic [63:0] q[$];
    logic        m_ovf = 1'b0;
    int          edge_n = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [15:0] ref_sat(input logic [31:0] v);
        longint x;
        x = longint'($signed(v));
        if (x > MAXV) return 16'h7FFF;
        if (x < MINV) return 16'h8000;
        return 16'(x >>> 10);
    endfunction

    function automatic logic [63:0] ref_row(input logic [127:0] r);
        logic [63:0] o;
        for (int c = 0; c < COLS; c++)
            o[c*16 +: 16] = ref_sat(r[c*32 +: 32]);
        return o;
    endfunction

    function automatic logic m_stall();
        return (q.size() + inflight.size()) >= DEPTH;
    endfunction

    function automatic logic [31:0] rand_elem();
        case ($urandom_range(0, 5))
            0: return 32'h01FF_FFFF;
            1: return 32'h0200_0000;
            2: return 32'hFE00_0000;
            3: return 32'hFDFF_FFFF;
            4: return 32'($signed($urandom_range(0, 32'h0400_0000)) - 32'sh0200_0000);
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [127:0] rand_row();
        logic [127:0] r;
        for (int c = 0; c < COLS; c++)
            r[c*32 +: 32] = rand_elem();
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("out_vld", 64'(out_vld_o), 64'(q.size() > 0));
        chk("level", 64'(level_o), 64'(q.size()));
        chk("stall", 64'(stall_o), 64'(m_stall()));
        chk("ovf", 64'(ovf_o), 64'(m_ovf));
        if (q.size() > 0)
            chk("head_data", out_data_o, q[0]);
    endtask

    task automatic step(input logic vld, input logic [127:0] row, input logic rdy, input logic clr);
        logic        pop, drop;
        fl_t         f;
        in_vld_i  = vld;
        out_rdy_i = rdy;
        clr_i     = clr;
        for (int c = 0; c < COLS; c++)
            o_i[c*32 +: 32] = $urandom;
        if (vld)
            o_i[31:0] = row[31:0];
        foreach (inflight[i]) begin
            int d;
            d = edge_n + 1 - inflight[i].e;
            if (d >= 1 && d < COLS)
                o_i[d*32 +: 32] = inflight[i].d[d*32 +: 32];
        end
        @(posedge clk);
        #1;
        edge_n++;
        pop  = (q.size() > 0) && rdy;
        drop = 1'b0;
        if (pop)
            void'(q.pop_front());
        if (inflight.size() > 0 && inflight[0].e == edge_n - COLS) begin
            f = inflight.pop_front();
            if (q.size() == DEPTH) drop = 1'b1;
            else q.push_back(ref_row(f.d));
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (vld) begin
            f.e = edge_n;
            f.d = row;
            inflight.push_back(f);
        end
        in_vld_i = 1'b0;
        clr_i    = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++)
            step(1'b0, '0, rdy, 1'b0);
    endtask

    initial begin
        logic [63:0] saved_head;
        int          stall_seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 64'(out_vld_o), 64'd0);
        chk("rst_data", out_data_o, 64'd0);
        chk("rst_level", 64'(level_o), 64'd0);
        chk("rst_ovf", 64'(ovf_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        rst = 1'b0;

        // Single row, (c+1)<<20 per column
        step(1'b1, {32'h0040_0000, 32'h0030_0000, 32'h0020_0000, 32'h0010_0000}, 1'b0, 1'b0);
        idle(3, 1'b0);
        chk("t1_not_yet", 64'(out_vld_o), 64'd0);
        idle(1, 1'b0);
        chk("t1_data", out_data_o, 64'h1000_0C00_0800_0400);
        chk("t1_level", 64'(level_o), 64'd1);
        idle(1, 1'b1);
        chk("t1_popped", 64'(level_o), 64'd0);

        // Saturation and boundaries
        step(1'b1, {32'hFDFF_FFFF, 32'hFE00_0000, 32'h01FF_FFFF, 32'h0200_0000}, 1'b0, 1'b0);
        step(1'b1, {4{32'hFFFF_FFFF}}, 1'b0, 1'b0);
        idle(4, 1'b0);
        chk("t2_sat", out_data_o, 64'h8000_8000_7FFF_7FFF);
        idle(1, 1'b1);
        chk("t2_neg1", out_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(2, 1'b1);

        // Streaming 16 rows back to back
        stall_seen = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, rand_row(), 1'b1, 1'b0);
            if (stall_o) stall_seen++;
        end
        for (int i = 0; i < 6; i++) begin
            idle(1, 1'b1);
            if (stall_o) stall_seen++;
        end
        chk("t3_no_stall", 64'(stall_seen), 64'd0);
        chk("t3_empty", 64'(level_o), 64'd0);

        // Backpressure: fill while stall low
        for (int i = 0; i < 20; i++)
            step(!m_stall(), rand_row(), 1'b0, 1'b0);
        chk("t4_full", 64'(level_o), 64'd8);
        chk("t4_stall", 64'(stall_o), 64'd1);
        idle(12, 1'b1);
        chk("t4_drained", 64'(level_o), 64'd0);

        // Overflow
        for (int i = 0; i < 12; i++)
            step(!m_stall(), rand_row(), 1'b0, 1'b0);
        saved_head = q[0];
        step(1'b1, rand_row(), 1'b0, 1'b0);
        idle(4, 1'b0);
        chk("t5_ovf", 64'(ovf_o), 64'd1);
        chk("t5_level", 64'(level_o), 64'd8);
        chk("t5_head", out_data_o, saved_head);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t5_clr", 64'(ovf_o), 64'd0);
        step(1'b1, rand_row(), 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t5_set_wins", 64'(ovf_o), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        idle(10, 1'b1);

        // Reset with 3 buffered and 2 pending
        for (int i = 0; i < 5; i++)
            step(1'b1, rand_row(), 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("t6_pre_level", 64'(level_o), 64'd3);
        rst = 1'b1;
        #1;
        chk("t6_vld", 64'(out_vld_o), 64'd0);
        chk("t6_level", 64'(level_o), 64'd0);
        chk("t6_stall", 64'(stall_o), 64'd0);
        chk("t6_data", out_data_o, 64'd0);
        q.delete();
        inflight.delete();
        m_ovf = 1'b0;
        #1;
        rst = 1'b0;
        idle(10, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic v;
            v = m_stall() ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
            step(v, rand_row(), $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
        end
        idle(20, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
